gpio_debounce: RTL and testbench
================================

GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 The block SHALL have parameter NumCh, default 5, giving the number of debounced channels (4 GPIO switches plus fetch-enable switch).
REQ-002 The block SHALL have parameter StableCycles, default 20000 (1 ms at 20 MHz soc_clk), giving the cycles an input must hold before acceptance; legal range 1 to 65535.
REQ-003 The block SHALL have parameter CntWidth, default 16, giving the counter width; it SHALL satisfy 2**CntWidth > StableCycles.
REQ-004 soc_clk  input  1  system clock; all state is clocked on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 raw_i  input  NumCh  asynchronous board switch levels.
REQ-007 bypass_i  input  1  quasi-static; when 1, the debounce filter is skipped.
REQ-008 clean_o  output  NumCh  debounced, synchronised levels driving SoC gpio_i and fetch_en_i.
REQ-009 rise_o  output  NumCh  one-cycle pulse on each accepted 0->1 transition of clean_o.
REQ-010 fall_o  output  NumCh  one-cycle pulse on each accepted 1->0 transition of clean_o.

Function
REQ-011 Each channel SHALL pass through a two-flop synchroniser (sync1, sync2) before any other logic.
REQ-012 Each channel SHALL have an independent CntWidth-bit counter cnt and a registered accepted level clean.
REQ-013 Each channel SHALL implement the two-state machine IDLE (sync2 == clean) / PENDING (sync2 != clean), the state being derived from that comparison.
REQ-014 In IDLE, cnt SHALL be 0.
REQ-015 In PENDING with cnt < StableCycles-1, cnt SHALL increment by 1 per cycle.
REQ-016 In PENDING with cnt == StableCycles-1, the next edge SHALL load clean <= sync2 and cnt <= 0.
REQ-017 If sync2 returns to clean before acceptance, cnt SHALL clear to 0 on the next edge (glitch rejected), with no partial credit retained.
REQ-018 A raw_i change held stable SHALL appear on clean_o on the (StableCycles+2)-th rising edge, counting the first edge that samples the new level as edge 1.
REQ-019 The counter SHALL never wrap; it is bounded by StableCycles-1 by construction.
REQ-020 With bypass_i=1, clean SHALL load sync2 every cycle (latency 2 edges), and all cnt SHALL be held at 0.
REQ-021 A change of bypass_i SHALL take effect on the next edge without corrupting clean.
REQ-022 rise_o[i] / fall_o[i] SHALL be registered and SHALL assert in exactly the cycle in which clean_o[i] shows the new value, for one cycle only.
REQ-023 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be accepted on their own schedule.

Reset
REQ-024 When rst_n=0, sync1, sync2, clean, cnt, rise_o and fall_o SHALL all be 0, asynchronously.
REQ-025 Reset asserted mid-count SHALL discard the pending transition.
REQ-026 After reset release, a channel whose raw_i is 1 SHALL be accepted through the normal latency of REQ-018 and SHALL produce a rise_o pulse.

Configuration
REQ-027 The macro GPIO_DEBOUNCE_EDGE_EN SHALL compile the edge-pulse logic in or out.
REQ-028 With GPIO_DEBOUNCE_EDGE_EN defined, rise_o and fall_o SHALL behave per REQ-022.
REQ-029 Without GPIO_DEBOUNCE_EDGE_EN, the rise_o/fall_o ports SHALL remain present, SHALL be tied to 0, and no edge registers SHALL be instantiated.
REQ-030 clean_o behaviour SHALL be identical with and without GPIO_DEBOUNCE_EDGE_EN.

Verification
REQ-031 Bench uses StableCycles=4, NumCh=5, GPIO_DEBOUNCE_EDGE_EN defined unless stated. Scenario: raw_i[0] 0->1 held -> clean_o[0]=1 on edge 6; rise_o[0]=1 for that cycle only.
REQ-032 Scenario: raw_i[1] 1-cycle-wide and then 3-cycle-wide high glitches -> clean_o[1] stays 0; cnt returns to 0; no rise_o pulse.
REQ-033 Scenario: raw_i=5'b10101 applied at once, then 5'b00000 after 20 cycles -> clean_o=5'b10101 on edge 6; fall_o=5'b10101 for one cycle on the matching later edge.
REQ-034 Scenario: bypass_i=1, raw_i[2] toggles each 3 cycles -> clean_o[2] follows with 2-edge latency; every accepted transition pulses rise_o or fall_o.
REQ-035 Scenario: rst_n asserted when cnt=2 on channel 3 -> all outputs 0 immediately; after release with raw_i[3]=1, clean_o[3]=1 on edge 6.
REQ-036 Scenario: rebuild without GPIO_DEBOUNCE_EDGE_EN, rerun REQ-031 -> identical clean_o timing; rise_o and fall_o constant 0.

Source files
------------

// File: rtl/gpio_debounce_if.sv
// rtl/gpio_debounce_if.sv - switch-side and SoC-side signal bundle for gpio_debounce
interface gpio_debounce_if #(
    parameter int NumCh = 5
);
    logic [NumCh-1:0] raw_i;
    logic             bypass_i;
    logic [NumCh-1:0] clean_o;
    logic [NumCh-1:0] rise_o;
    logic [NumCh-1:0] fall_o;

    modport master (
        output raw_i,
        output bypass_i,
        input  clean_o,
        input  rise_o,
        input  fall_o
    );

    modport slave (
        input  raw_i,
        input  bypass_i,
        output clean_o,
        output rise_o,
        output fall_o
    );
endinterface

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - per-channel synchroniser and debounce filter for board switches
// Edge-pulse registers are compiled in only when GPIO_DEBOUNCE_EDGE_EN is defined.
module gpio_debounce #(
    parameter int NumCh        = 5,
    parameter int StableCycles = 20000,
    parameter int CntWidth     = 16
) (
    input logic             soc_clk,
    input logic             rst_n,
    gpio_debounce_if.slave  dbif
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    localparam logic [CntWidth-1:0] CntLast = CntWidth'(StableCycles - 1);
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

    logic [NumCh-1:0]    sync1_q, sync1_d;
    logic [NumCh-1:0]    sync2_q, sync2_d;
    logic [NumCh-1:0]    clean_q, clean_d;
    logic [CntWidth-1:0] cnt_q [NumCh];
    logic [CntWidth-1:0] cnt_d [NumCh];
    state_e              state [NumCh];

    // The filter state is not stored: a channel is pending whenever the
    // synchronised level disagrees with the accepted level.
    always_comb begin
        sync1_d = dbif.raw_i;
        sync2_d = sync1_q;
        for (int i = 0; i < NumCh; i++) begin
            state[i]   = (sync2_q[i] != clean_q[i]) ? PENDING : IDLE;
            clean_d[i] = clean_q[i];
            cnt_d[i]   = '0;
            if (dbif.bypass_i) begin
                clean_d[i] = sync2_q[i];
            end else begin
                unique case (state[i])
                    IDLE: begin
                        cnt_d[i] = '0;
                    end
                    PENDING: begin
                        if (cnt_q[i] == CntLast) begin
                            clean_d[i] = sync2_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CntOne;
                        end
                    end
                    default: begin
                        cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            for (int i = 0; i < NumCh; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            for (int i = 0; i < NumCh; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign dbif.clean_o = clean_q;

`ifdef GPIO_DEBOUNCE_EDGE_EN
    logic [NumCh-1:0] rise_q, rise_d;
    logic [NumCh-1:0] fall_q, fall_d;

    // Pulses are derived from the next accepted level so they line up with clean_o.
    always_comb begin
        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;
    end

    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dbif.rise_o = rise_q;
    assign dbif.fall_o = fall_q;
`else
    assign dbif.rise_o = '0;
    assign dbif.fall_o = '0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// tb/tb_gpio_debounce.sv - directed self-checking bench for gpio_debounce (StableCycles=4)
module tb_gpio_debounce;

`ifdef GPIO_DEBOUNCE_EDGE_EN
    localparam logic [4:0] EdgeMask = 5'b11111;
`else
    localparam logic [4:0] EdgeMask = 5'b00000;
`endif

    logic soc_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [4:0] p1, p2, p3, prev3;

    gpio_debounce_if #(.NumCh(5)) dbif ();

    gpio_debounce #(
        .NumCh(5),
        .StableCycles(4),
        .CntWidth(16)
    ) dut (
        .soc_clk(soc_clk),
        .rst_n(rst_n),
        .dbif(dbif)
    );

    always #5 soc_clk = ~soc_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One rising edge, then a 1 ns settle; also advances the bypass-path model.
    task automatic step();
        @(posedge soc_clk);
        prev3 = p3;
        p3 = p2;
        p2 = p1;
        p1 = dbif.raw_i;
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        dbif.raw_i    = 5'b11111;
        dbif.bypass_i = 1'b0;
        p1 = '0; p2 = '0; p3 = '0; prev3 = '0;
        #2;
        check("rst_clean", dbif.clean_o, 5'b0);
        check("rst_rise", dbif.rise_o, 5'b0);
        check("rst_fall", dbif.fall_o, 5'b0);
        steps(3);
        check("rst_hold_clean", dbif.clean_o, 5'b0);
        dbif.raw_i = 5'b0;
        steps(2);
        rst_n = 1'b1;
        steps(3);

        // single channel rise then fall
        dbif.raw_i = 5'b00001;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("s1_clean_wait", dbif.clean_o, 5'b0);
        end
        step();
        check("s1_clean_e6", dbif.clean_o, 5'b00001);
        check("s1_rise_e6", dbif.rise_o, 5'b00001 & EdgeMask);
        step();
        check("s1_rise_e7", dbif.rise_o, 5'b0);
        check("s1_clean_e7", dbif.clean_o, 5'b00001);
        dbif.raw_i = 5'b00000;
        steps(5);
        check("s1_fall_wait", dbif.clean_o, 5'b00001);
        check("s1_fall_early", dbif.fall_o, 5'b0);
        step();
        check("s1_fall_clean", dbif.clean_o, 5'b0);
        check("s1_fall_pulse", dbif.fall_o, 5'b00001 & EdgeMask);
        step();
        check("s1_fall_end", dbif.fall_o, 5'b0);
        steps(2);

        // glitches on channel 1
        dbif.raw_i = 5'b00010;
        step();
        dbif.raw_i = 5'b00000;
        for (int k = 0; k < 8; k++) begin
            step();
            check("g1_clean", dbif.clean_o, 5'b0);
            check("g1_rise", dbif.rise_o, 5'b0);
        end
        dbif.raw_i = 5'b00010;
        steps(3);
        dbif.raw_i = 5'b00000;
        for (int k = 0; k < 8; k++) begin
            step();
            check("g3_clean", dbif.clean_o, 5'b0);
            check("g3_rise", dbif.rise_o, 5'b0);
        end
        // 3-wide glitch, one low sample, then a sustained high: full latency from re-rise
        dbif.raw_i = 5'b00010;
        steps(3);
        dbif.raw_i = 5'b00000;
        step();
        dbif.raw_i = 5'b00010;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("g_credit_wait", dbif.clean_o, 5'b0);
        end
        step();
        check("g_credit_accept", dbif.clean_o, 5'b00010);
        check("g_credit_rise", dbif.rise_o, 5'b00010 & EdgeMask);
        dbif.raw_i = 5'b00000;
        steps(8);
        check("g_restore", dbif.clean_o, 5'b0);

        // multi-channel simultaneous
        dbif.raw_i = 5'b10101;
        steps(5);
        check("m_wait", dbif.clean_o, 5'b0);
        step();
        check("m_clean_e6", dbif.clean_o, 5'b10101);
        check("m_rise_e6", dbif.rise_o, 5'b10101 & EdgeMask);
        for (int k = 7; k <= 20; k++) begin
            step();
            check("m_hold_rise", dbif.rise_o, 5'b0);
        end
        check("m_hold_clean", dbif.clean_o, 5'b10101);
        dbif.raw_i = 5'b00000;
        steps(5);
        check("m_fall_wait", dbif.clean_o, 5'b10101);
        step();
        check("m_fall_clean", dbif.clean_o, 5'b0);
        check("m_fall_pulse", dbif.fall_o, 5'b10101 & EdgeMask);
        step();
        check("m_fall_end", dbif.fall_o, 5'b0);
        steps(2);

        // bypass: clean follows raw through sync1, sync2, clean
        dbif.bypass_i = 1'b1;
        p1 = '0; p2 = '0; p3 = '0;
        for (int k = 0; k < 21; k++) begin
            if (k % 3 == 0) dbif.raw_i[2] = ~dbif.raw_i[2];
            step();
            check("byp_clean", dbif.clean_o, p3);
            check("byp_rise", dbif.rise_o, p3 & ~prev3 & EdgeMask);
            check("byp_fall", dbif.fall_o, ~p3 & prev3 & EdgeMask);
        end
        dbif.raw_i = 5'b0;
        steps(4);
        check("byp_clear", dbif.clean_o, 5'b0);
        dbif.bypass_i = 1'b0;
        steps(2);

        // reset mid-count on channel 3
        dbif.raw_i = 5'b00001;
        steps(6);
        check("r_pre_clean", dbif.clean_o, 5'b00001);
        dbif.raw_i = 5'b01001;
        steps(4);
        rst_n = 1'b0;
        #1;
        check("r_async_clean", dbif.clean_o, 5'b0);
        check("r_async_rise", dbif.rise_o, 5'b0);
        check("r_async_fall", dbif.fall_o, 5'b0);
        steps(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("r_wait", dbif.clean_o, 5'b0);
        end
        step();
        check("r_clean_e6", dbif.clean_o, 5'b01001);
        check("r_rise_e6", dbif.rise_o, 5'b01001 & EdgeMask);
        step();
        check("r_rise_e7", dbif.rise_o, 5'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
